// File: rtl/lc3_datapath_p_if.sv
// Control and data bundle between the ISDU/memory side and the LC-3 datapath.
// The signals are level-controlled each cycle; there is no valid/ready handshake.
interface lc3_datapath_p_if #(
  parameter int WIDTH = 16,
  parameter int LED_W = 12
);
  logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic             GatePC, GateMDR, GateALU, GateMARMUX;
  logic             MIO_EN;
  logic [1:0]       PCMUX;
  logic             DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0]       ADDR2MUX;
  logic [1:0]       ALUK;
  logic [WIDTH-1:0] MDR_In;
  logic [WIDTH-1:0] MDR, MAR, IR, PC;
  logic             BEN;
  logic [LED_W-1:0] LED;
  logic             bus_err;

  modport master (
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN, PCMUX,
    output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MDR_In,
    input  MDR, MAR, IR, PC, BEN, LED, bus_err
  );

  modport slave (
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN, PCMUX,
    input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MDR_In,
    output MDR, MAR, IR, PC, BEN, LED, bus_err
  );
endinterface

// File: rtl/lc3_datapath_p.sv
// Registered LC-3 datapath: bus/gate mux, PC/MAR/MDR/IR, regfile, ALU, address adder, CC, BEN, LED.
// Optional macro LC3_BUS_CONTENTION_CHECK_EN enables the sticky bus_err contention flag.
module lc3_datapath_p #(
  parameter int               WIDTH    = 16,
  parameter int               LED_W    = 12,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input logic Clk,
  input logic Reset,
  lc3_datapath_p_if.slave dp
);
  logic [WIDTH-1:0] pc_q, mar_q, mdr_q, ir_q;
  logic [WIDTH-1:0] regs [8];
  logic [2:0]       cc_q;  // {N, Z, P}
  logic             ben_q;
  logic [LED_W-1:0] led_q;

  logic [WIDTH-1:0] bus, alu_out, addr_sum, addr1, addr2, sr1_data, sr2_data, alu_b, pc_next;
  logic [2:0]       sr1_addr, dr_addr;
  logic [2:0]       cc_next;

  // Read ports are purely combinational, so a same-cycle write is seen only after the edge.
  assign sr1_addr = dp.SR1MUX ? ir_q[11:9] : ir_q[8:6];
  assign dr_addr  = dp.DRMUX  ? 3'd7       : ir_q[11:9];
  assign sr1_data = regs[sr1_addr];
  assign sr2_data = regs[ir_q[2:0]];
  assign alu_b    = dp.SR2MUX ? WIDTH'($signed(ir_q[4:0])) : sr2_data;

  always_comb begin
    alu_out = '0;
    case (dp.ALUK)
      2'b00: alu_out = sr1_data + alu_b;
      2'b01: alu_out = sr1_data & alu_b;
      2'b10: alu_out = ~sr1_data;
      2'b11: alu_out = sr1_data;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    addr2 = '0;
    case (dp.ADDR2MUX)
      2'b00: addr2 = '0;
      2'b01: addr2 = WIDTH'($signed(ir_q[5:0]));
      2'b10: addr2 = WIDTH'($signed(ir_q[8:0]));
      2'b11: addr2 = WIDTH'($signed(ir_q[10:0]));
      default: addr2 = '0;
    endcase
  end

  assign addr1    = dp.ADDR1MUX ? sr1_data : pc_q;
  assign addr_sum = addr1 + addr2;

  // Fixed priority keeps the bus defined even when the controller double-gates.
  always_comb begin
    bus = '0;
    if (dp.GatePC)          bus = pc_q;
    else if (dp.GateMDR)    bus = mdr_q;
    else if (dp.GateALU)    bus = alu_out;
    else if (dp.GateMARMUX) bus = addr_sum;
  end

  always_comb begin
    pc_next = pc_q;
    case (dp.PCMUX)
      2'b00: pc_next = pc_q + 1'b1;
      2'b01: pc_next = bus;
      2'b10: pc_next = addr_sum;
      2'b11: pc_next = pc_q;
      default: pc_next = pc_q;
    endcase
  end

  always_comb begin
    cc_next = 3'b001;
    if (bus[WIDTH-1])   cc_next = 3'b100;
    else if (bus == '0) cc_next = 3'b010;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= PC_RESET;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      cc_q  <= 3'b010;
      ben_q <= 1'b0;
      led_q <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (dp.LD_MAR) mar_q <= bus;
      if (dp.LD_MDR) mdr_q <= dp.MIO_EN ? dp.MDR_In : bus;
      if (dp.LD_IR)  ir_q  <= bus;
      if (dp.LD_PC)  pc_q  <= pc_next;
      if (dp.LD_REG) regs[dr_addr] <= bus;
      if (dp.LD_CC)  cc_q  <= cc_next;
      // BEN uses the registered CC, so a simultaneous LD_CC does not affect it.
      if (dp.LD_BEN) ben_q <= (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);
      if (dp.LD_LED) led_q <= ir_q[LED_W-1:0];
    end
  end

`ifdef LC3_BUS_CONTENTION_CHECK_EN
  logic bus_err_q;
  logic multi_gate;
  assign multi_gate = (dp.GatePC  & (dp.GateMDR | dp.GateALU | dp.GateMARMUX)) |
                      (dp.GateMDR & (dp.GateALU | dp.GateMARMUX)) |
                      (dp.GateALU & dp.GateMARMUX);
  always_ff @(posedge Clk) begin
    if (Reset)           bus_err_q <= 1'b0;
    else if (multi_gate) bus_err_q <= 1'b1;
  end
  assign dp.bus_err = bus_err_q;
`else
  assign dp.bus_err = 1'b0;
`endif

  assign dp.PC  = pc_q;
  assign dp.MAR = mar_q;
  assign dp.MDR = mdr_q;
  assign dp.IR  = ir_q;
  assign dp.BEN = ben_q;
  assign dp.LED = led_q;
endmodule

// File: tb/tb_lc3_datapath_p.sv
// Directed bench for lc3_datapath_p: each scenario task drives control words and checks inline.
module tb_lc3_datapath_p;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lc3_datapath_p_if #(.WIDTH(16), .LED_W(12)) dp_if ();

  lc3_datapath_p #(.WIDTH(16), .LED_W(12), .PC_RESET(16'h0000)) dut (
    .Clk   (clk),
    .Reset (reset),
    .dp    (dp_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_ctl();
    dp_if.LD_MAR = 0; dp_if.LD_MDR = 0; dp_if.LD_IR = 0; dp_if.LD_BEN = 0;
    dp_if.LD_CC = 0; dp_if.LD_REG = 0; dp_if.LD_PC = 0; dp_if.LD_LED = 0;
    dp_if.GatePC = 0; dp_if.GateMDR = 0; dp_if.GateALU = 0; dp_if.GateMARMUX = 0;
    dp_if.MIO_EN = 0; dp_if.PCMUX = 2'b00; dp_if.DRMUX = 0; dp_if.SR1MUX = 0;
    dp_if.SR2MUX = 0; dp_if.ADDR1MUX = 0; dp_if.ADDR2MUX = 2'b00; dp_if.ALUK = 2'b00;
    dp_if.MDR_In = 16'h0000;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    clear_ctl();
    dp_if.MIO_EN = 1; dp_if.LD_MDR = 1; dp_if.MDR_In = v;
    step();
    clear_ctl();
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v);
    dp_if.GateMDR = 1; dp_if.LD_IR = 1;
    step();
    clear_ctl();
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_mdr(v);
    dp_if.GateMDR = 1; dp_if.PCMUX = 2'b01; dp_if.LD_PC = 1;
    step();
    clear_ctl();
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] v);
    set_ir({4'b0000, idx, 9'b0});
    load_mdr(v);
    dp_if.GateMDR = 1; dp_if.LD_REG = 1; dp_if.DRMUX = 0;
    step();
    clear_ctl();
  endtask

  // Copies reg[idx] into MAR through the ALU pass-A path.
  task automatic read_reg_to_mar(input logic [2:0] idx);
    set_ir({7'b0, idx, 6'b0});
    dp_if.SR1MUX = 0; dp_if.ALUK = 2'b11; dp_if.GateALU = 1; dp_if.LD_MAR = 1;
    step();
    clear_ctl();
  endtask

  task automatic test_reset();
    set_pc(16'h1234);
    load_mdr(16'hBEEF);
    reset = 1;
    dp_if.LD_MAR = 1; dp_if.LD_MDR = 1; dp_if.LD_IR = 1; dp_if.LD_BEN = 1;
    dp_if.LD_CC = 1; dp_if.LD_REG = 1; dp_if.LD_PC = 1; dp_if.LD_LED = 1;
    dp_if.GateMDR = 1; dp_if.MIO_EN = 1; dp_if.MDR_In = 16'h5A5A;
    step();
    reset = 0;
    clear_ctl();
    checks++;
    if (dp_if.PC !== 16'h0000 || dp_if.MAR !== 16'h0000 || dp_if.MDR !== 16'h0000 ||
        dp_if.IR !== 16'h0000 || dp_if.BEN !== 1'b0 || dp_if.LED !== 12'h000 ||
        dp_if.bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual PC=%h MAR=%h MDR=%h IR=%h BEN=%b LED=%h err=%b required all zero",
               dp_if.PC, dp_if.MAR, dp_if.MDR, dp_if.IR, dp_if.BEN, dp_if.LED, dp_if.bus_err);
    end
    // CC resets to Z: BRz sets BEN, BRn does not.
    set_ir(16'h0400);
    dp_if.LD_BEN = 1; step(); clear_ctl();
    checks++;
    if (dp_if.BEN !== 1'b1) begin
      failures++; $display("FAIL reset_cc_z BEN actual=%b required=1", dp_if.BEN);
    end
    set_ir(16'h0A00);
    dp_if.LD_BEN = 1; step(); clear_ctl();
    checks++;
    if (dp_if.BEN !== 1'b0) begin
      failures++; $display("FAIL reset_cc_not_np BEN actual=%b required=0", dp_if.BEN);
    end
  endtask

  task automatic test_fetch();
    set_pc(16'h3000);
    dp_if.GatePC = 1; dp_if.LD_MAR = 1; dp_if.PCMUX = 2'b00; dp_if.LD_PC = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h3000 || dp_if.PC !== 16'h3001) begin
      failures++;
      $display("FAIL fetch_step1 actual MAR=%h PC=%h required MAR=3000 PC=3001", dp_if.MAR, dp_if.PC);
    end
    dp_if.MIO_EN = 1; dp_if.LD_MDR = 1; dp_if.MDR_In = 16'h1234;
    step(); clear_ctl();
    checks++;
    if (dp_if.MDR !== 16'h1234) begin
      failures++; $display("FAIL fetch_mdr actual=%h required=1234", dp_if.MDR);
    end
    dp_if.GateMDR = 1; dp_if.LD_IR = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.IR !== 16'h1234) begin
      failures++; $display("FAIL fetch_ir actual=%h required=1234", dp_if.IR);
    end
    dp_if.LD_LED = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.LED !== 12'h234) begin
      failures++; $display("FAIL led_latch actual=%h required=234", dp_if.LED);
    end
    // No load enables: everything holds.
    step(); step();
    checks++;
    if (dp_if.PC !== 16'h3001 || dp_if.MAR !== 16'h3000 || dp_if.IR !== 16'h1234) begin
      failures++;
      $display("FAIL hold actual PC=%h MAR=%h IR=%h required 3001/3000/1234", dp_if.PC, dp_if.MAR, dp_if.IR);
    end
  endtask

  task automatic test_pc_wrap();
    set_pc(16'hFFFF);
    dp_if.PCMUX = 2'b00; dp_if.LD_PC = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.PC !== 16'h0000) begin
      failures++; $display("FAIL pc_wrap actual=%h required=0000", dp_if.PC);
    end
  endtask

  task automatic test_add();
    write_reg(3'd1, 16'h7FFF);
    write_reg(3'd2, 16'h0001);
    set_ir(16'h1042);
    dp_if.GateALU = 1; dp_if.ALUK = 2'b00; dp_if.LD_REG = 1; dp_if.LD_CC = 1;
    step(); clear_ctl();
    read_reg_to_mar(3'd0);
    checks++;
    if (dp_if.MAR !== 16'h8000) begin
      failures++; $display("FAIL add_r0 actual=%h required=8000", dp_if.MAR);
    end
    set_ir(16'h0800);
    dp_if.LD_BEN = 1; step(); clear_ctl();
    checks++;
    if (dp_if.BEN !== 1'b1) begin
      failures++; $display("FAIL add_cc_n_ben actual=%b required=1", dp_if.BEN);
    end
    // Bus is zero with no gate; LD_CC+LD_BEN together must use the old N.
    dp_if.LD_CC = 1; dp_if.LD_BEN = 1; step(); clear_ctl();
    checks++;
    if (dp_if.BEN !== 1'b1) begin
      failures++; $display("FAIL ben_old_cc actual=%b required=1", dp_if.BEN);
    end
    dp_if.LD_BEN = 1; step(); clear_ctl();
    checks++;
    if (dp_if.BEN !== 1'b0) begin
      failures++; $display("FAIL ben_new_cc_z actual=%b required=0", dp_if.BEN);
    end
  endtask

  task automatic test_alu_ops();
    set_ir(16'h5042);
    dp_if.GateALU = 1; dp_if.ALUK = 2'b01; dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h0001) begin
      failures++; $display("FAIL alu_and actual=%h required=0001", dp_if.MAR);
    end
    dp_if.GateALU = 1; dp_if.ALUK = 2'b10; dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h8000) begin
      failures++; $display("FAIL alu_not actual=%h required=8000", dp_if.MAR);
    end
    set_ir(16'h107F);
    dp_if.GateALU = 1; dp_if.ALUK = 2'b00; dp_if.SR2MUX = 1; dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h7FFE) begin
      failures++; $display("FAIL alu_add_imm actual=%h required=7FFE", dp_if.MAR);
    end
  endtask

  task automatic test_addr_adder();
    set_pc(16'h3000);
    set_ir(16'h01FF);
    dp_if.GateMARMUX = 1; dp_if.ADDR1MUX = 0; dp_if.ADDR2MUX = 2'b10; dp_if.LD_MAR = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h2FFF) begin
      failures++; $display("FAIL addr_pc_off9 actual=%h required=2FFF", dp_if.MAR);
    end
    dp_if.GateMARMUX = 1; dp_if.ADDR2MUX = 2'b11; dp_if.LD_MAR = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h31FF) begin
      failures++; $display("FAIL addr_pc_off11 actual=%h required=31FF", dp_if.MAR);
    end
    // R7 via DRMUX, then base+offset6 into both MAR and PC in one cycle.
    set_ir(16'h0000);
    load_mdr(16'h0100);
    dp_if.GateMDR = 1; dp_if.DRMUX = 1; dp_if.LD_REG = 1; step(); clear_ctl();
    set_ir(16'h01C5);
    dp_if.GateMARMUX = 1; dp_if.ADDR1MUX = 1; dp_if.ADDR2MUX = 2'b01; dp_if.LD_MAR = 1;
    dp_if.PCMUX = 2'b10; dp_if.LD_PC = 1;
    step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h0105 || dp_if.PC !== 16'h0105) begin
      failures++;
      $display("FAIL addr_r7_off6 actual MAR=%h PC=%h required 0105/0105", dp_if.MAR, dp_if.PC);
    end
  endtask

  task automatic test_no_gate();
    load_mdr(16'hABCD);
    dp_if.GateMDR = 1; dp_if.LD_MAR = 1; step(); clear_ctl();
    dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h0000) begin
      failures++; $display("FAIL no_gate_bus actual=%h required=0000", dp_if.MAR);
    end
  endtask

  task automatic test_contention();
    logic exp_err;
`ifdef LC3_BUS_CONTENTION_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    set_pc(16'h4000);
    load_mdr(16'h0F0F);
    checks++;
    if (dp_if.bus_err !== 1'b0) begin
      failures++; $display("FAIL err_quiet actual=%b required=0", dp_if.bus_err);
    end
    dp_if.GatePC = 1; dp_if.GateALU = 1; dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h4000 || dp_if.bus_err !== exp_err) begin
      failures++;
      $display("FAIL contention actual MAR=%h err=%b required MAR=4000 err=%b", dp_if.MAR, dp_if.bus_err, exp_err);
    end
    dp_if.GateMDR = 1; dp_if.GateMARMUX = 1; dp_if.LD_MAR = 1; step(); clear_ctl();
    checks++;
    if (dp_if.MAR !== 16'h0F0F) begin
      failures++; $display("FAIL prio_mdr actual=%h required=0F0F", dp_if.MAR);
    end
    step(); step(); step();
    checks++;
    if (dp_if.bus_err !== exp_err) begin
      failures++; $display("FAIL err_sticky actual=%b required=%b", dp_if.bus_err, exp_err);
    end
    reset = 1; step(); reset = 0;
    checks++;
    if (dp_if.bus_err !== 1'b0 || dp_if.PC !== 16'h0000) begin
      failures++;
      $display("FAIL err_cleared actual err=%b PC=%h required 0/0000", dp_if.bus_err, dp_if.PC);
    end
  endtask

  // Scenario sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    clear_ctl();
    reset = 1;
    step(); step();
    reset = 0;
    test_reset();
    test_fetch();
    test_pc_wrap();
    test_add();
    test_alu_ops();
    test_addr_adder();
    test_no_gate();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3_datapath_p.md
Name: lc3_datapath_p

Overview:
- Parametrised, fully registered LC-3 datapath for the lab CPU.
- Contains the single internal bus and its gate mux, plus the PC, MAR, MDR and IR registers.
- Also contains an 8-entry register file, ALU, address adder, NZP condition codes, the BEN flag and the LED latch.
- Driven cycle-by-cycle by the ISDU control FSM; talks to memory through the existing MIO tristate path (MDR_In in, MDR/MAR out).

Parameters:
- WIDTH, 16, datapath/bus/register width; ISA field positions fixed in IR[15:0]; WIDTH >= 16; sign-extends to WIDTH.
- LED_W, 12, number of IR low bits latched onto LED.
- PC_RESET, 0, PC value loaded on Reset.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus source selects
- MIO_EN  in  1  MDR source: 1 = MDR_In (memory), 0 = BUS
- PCMUX  in  2  00 PC+1, 01 BUS, 10 address adder, 11 PC (hold)
- DRMUX  in  1  0 IR[11:9], 1 R7
- SR1MUX  in  1  0 IR[8:6], 1 IR[11:9]
- SR2MUX  in  1  0 reg[IR[2:0]], 1 sext(IR[4:0])
- ADDR1MUX  in  1  0 PC, 1 SR1 data
- ADDR2MUX  in  2  00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0])
- ALUK  in  2  00 A+B, 01 A&B, 10 ~A, 11 pass A
- MDR_In  in  WIDTH  memory read data
- MDR, MAR, IR, PC  out  WIDTH each  register contents
- BEN  out  1  branch enable
- LED  out  LED_W  latched IR[LED_W-1:0]
- bus_err  out  1  bus contention flag (see Optional Feature)

Behaviour:
- Reset (synchronous, highest priority): PC=PC_RESET; MAR, MDR, IR, all 8 regs = 0; CC = 3'b010 (Z); BEN=0; LED=0; bus_err=0.
- BUS (combinational):
  - Exactly one gate asserted -> that source: PC, MDR, ALU result, or address-adder result (MARMUX).
  - No gate asserted -> all-zero, never X.
  - More than one gate -> priority PC > MDR > ALU > MARMUX.
- Register loads:
  - All registers are true flops; loads take effect at the next rising Clk, and new values are visible the cycle after the load enable.
  - With no load enable, every register holds its value.
  - Multiple load enables in one cycle are legal; each register samples the pre-edge BUS/mux values.
- MAR <= BUS on LD_MAR.
- MDR on LD_MDR: MDR_In if MIO_EN, else BUS.
- IR <= BUS on LD_IR.
- PC on LD_PC: loaded per PCMUX. PC+1 wraps modulo 2^WIDTH (0xFFFF -> 0x0000 at WIDTH=16).
- Register file:
  - Two combinational read ports: SR1 address from SR1MUX; SR2 address from IR[2:0].
  - One write port: on LD_REG, reg[DR] <= BUS.
  - Read during write returns the old value.
- ALU: A = SR1 data, B = SR2MUX output. Add is modulo 2^WIDTH, with no carry or overflow flag.
- Address adder: ADDR1MUX + ADDR2MUX, modulo 2^WIDTH.
- CC on LD_CC, from BUS:
  - N = BUS[WIDTH-1]; Z = (BUS==0); P = otherwise.
  - Exactly one bit set.
- BEN on LD_BEN: BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using registered CC and IR. Simultaneous LD_CC and LD_BEN uses the old CC.
- LED <= IR[LED_W-1:0] on LD_LED.
- Reset asserted mid-sequence overrides all loads that cycle.

Optional Feature:
- Macro: LC3_BUS_CONTENTION_CHECK_EN
- Defined:
  - bus_err is a registered sticky flag, set on any rising Clk where more than one Gate* is high.
  - Cleared only by Reset.
  - BUS still resolves by the stated priority.
- Undefined: bus_err tied to 0; no contention logic is synthesised.

Test Plan:
- Reset with all loads high -> PC=0x0000, MAR=MDR=IR=0, CC=Z, BEN=0, LED=0 next cycle.
- Fetch:
  - Step 1: GatePC+LD_MAR, PCMUX=00+LD_PC from PC=0x3000 -> MAR=0x3000, PC=0x3001 after one edge.
  - Step 2: MIO_EN+LD_MDR with MDR_In=0x1234 -> MDR=0x1234.
  - Step 3: GateMDR+LD_IR -> IR=0x1234.
- PC wrap: PC=0xFFFF, PCMUX=00, LD_PC -> PC=0x0000.
- ADD:
  - Setup: R1=0x7FFF, R2=0x0001, IR=0x1042 (ADD R0,R1,R2).
  - Action: GateALU, ALUK=00, LD_REG, LD_CC.
  - Expected: R0=0x8000, CC=N.
  - Follow-up: IR=0x0800 (BRn), then LD_BEN -> BEN=1.
- No gate asserted with LD_MAR -> MAR=0x0000.
- Macro defined, GatePC and GateALU both high one cycle:
  - BUS equals PC.
  - bus_err=1 and stays 1 until Reset.
  - With macro undefined, bus_err stays 0.
